// File: rtl/tx_pkt_saf_buf.sv
// rtl/tx_pkt_saf_buf.sv - store-and-forward TX packet buffer
// Packets become visible at the output only after a clean eop commits them.
module tx_pkt_saf_buf #(
   parameter int DWIDTH      = 64,
   parameter int AWIDTH      = 9,
   parameter int PCW         = 8,
   parameter int DROP_ON_ERR = 1,
   localparam int EW         = $clog2(DWIDTH / 8)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DWIDTH-1:0] in_data_i,
   input  logic [EW-1:0]     in_empty_i,
   input  logic              in_sop_i,
   input  logic              in_eop_i,
   input  logic              in_err_i,
   input  logic              in_val_i,
   output logic              in_ready_o,
   output logic [DWIDTH-1:0] out_data_o,
   output logic [EW-1:0]     out_empty_o,
   output logic              out_sop_o,
   output logic              out_eop_o,
   output logic              out_val_o,
   input  logic              out_ready_i,
   input  logic              flush_i,
   output logic [PCW-1:0]    pkt_cnt_o,
   output logic [AWIDTH:0]   used_words_o,
   output logic [15:0]       drop_cnt_o
);

   localparam int PW = AWIDTH + 1;
   localparam int WW = DWIDTH + EW + 2;
   localparam logic [PW-1:0]  DEPTH_P = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [PCW-1:0] PKT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} wstate_t;

   wstate_t           state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PCW-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]     used_q, used_d;
   logic              out_val_q, out_val_d;
   logic [WW-1:0]     out_word_q, out_word_d;
   logic              ready_q;

   logic [WW-1:0]     mem_q [0:(1<<AWIDTH)-1];
   logic              mem_we;
   logic [AWIDTH-1:0] mem_waddr;
   logic [WW-1:0]     mem_wdata;

   logic              in_acc, out_acc, err_drop, write_try, commit, load;
   logic [1:0]        drop_add;
   logic [PW-1:0]     base_ptr, fetch_ptr;
   logic [16:0]       drop_sum;

   assign in_ready_o = ready_q && !(state_q == S_IDLE && pkt_cnt_q == PKT_MAX);

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      mem_we       = 1'b0;
      mem_waddr    = wr_ptr_q[AWIDTH-1:0];
      mem_wdata    = {in_data_i, in_empty_i, in_sop_i, in_eop_i};
      commit       = 1'b0;
      drop_add     = 2'd0;
      base_ptr     = wr_ptr_q;
      write_try    = 1'b0;
      in_acc       = in_val_i && in_ready_o;
      err_drop     = (DROP_ON_ERR != 0) && in_err_i;

      if (in_acc) begin
         case (state_q)
            S_IDLE:    write_try = in_sop_i;
            S_WRITE: begin
               write_try = 1'b1;
               // A fresh sop abandons the unfinished packet and restarts at commit_ptr.
               if (in_sop_i) begin
                  base_ptr = commit_ptr_q;
                  drop_add = 2'd1;
               end
            end
            S_DISCARD: if (in_eop_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end

      if (write_try) begin
         if ((base_ptr - rd_ptr_q) == DEPTH_P) begin
            wr_ptr_d = commit_ptr_q;
            drop_add = drop_add + 2'd1;
            state_d  = in_eop_i ? S_IDLE : S_DISCARD;
         end else if (in_eop_i && err_drop) begin
            wr_ptr_d = commit_ptr_q;
            drop_add = drop_add + 2'd1;
            state_d  = S_IDLE;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = base_ptr[AWIDTH-1:0];
            wr_ptr_d  = base_ptr + PW'(1);
            if (in_eop_i) begin
               commit_ptr_d = base_ptr + PW'(1);
               commit       = 1'b1;
               state_d      = S_IDLE;
            end else begin
               state_d = S_WRITE;
            end
         end
      end

      // rd_ptr counts the output register as occupied, so the fetch address is one ahead when it holds a word.
      out_acc   = out_val_q && out_ready_i;
      fetch_ptr = rd_ptr_q + PW'(out_val_q);
      load      = (commit_ptr_q != fetch_ptr) && (!out_val_q || out_ready_i);
      if (out_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      out_val_d  = (out_val_q && !out_ready_i) || load;
      out_word_d = load ? mem_q[fetch_ptr[AWIDTH-1:0]] : out_word_q;

      pkt_cnt_d  = pkt_cnt_q + PCW'(commit) - PCW'(out_acc && out_word_q[0]);
      drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_add);
      drop_cnt_d = drop_sum[16] ? 16'hffff : drop_sum[15:0];

      if (flush_i) begin
         mem_we       = 1'b0;
         wr_ptr_d     = '0;
         commit_ptr_d = '0;
         rd_ptr_d     = '0;
         pkt_cnt_d    = '0;
         out_val_d    = 1'b0;
         drop_cnt_d   = drop_cnt_q;
         state_d      = (state_q == S_WRITE && !(in_acc && in_eop_i)) ? S_DISCARD : S_IDLE;
      end

      used_d = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         pkt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         used_q       <= '0;
         out_val_q    <= 1'b0;
         out_word_q   <= '0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pkt_cnt_q    <= pkt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         used_q       <= used_d;
         out_val_q    <= out_val_d;
         out_word_q   <= out_word_d;
         ready_q      <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign out_val_o    = out_val_q;
   assign out_data_o   = out_word_q[WW-1 -: DWIDTH];
   assign out_empty_o  = out_word_q[EW+1:2];
   assign out_sop_o    = out_word_q[1];
   assign out_eop_o    = out_word_q[0];
   assign pkt_cnt_o    = pkt_cnt_q;
   assign used_words_o = used_q;
   assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_tx_pkt_saf_buf.sv
// tb/tb_tx_pkt_saf_buf.sv - directed self-checking bench for tx_pkt_saf_buf
module tb_tx_pkt_saf_buf;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [63:0] in_data_i;
   logic [2:0]  in_empty_i;
   logic        in_sop_i, in_eop_i, in_err_i, in_val_i;
   logic        in_ready_o;
   logic [63:0] out_data_o;
   logic [2:0]  out_empty_o;
   logic        out_sop_o, out_eop_o, out_val_o;
   logic        out_ready_i;
   logic        flush_i;
   logic [7:0]  pkt_cnt_o;
   logic [4:0]  used_words_o;
   logic [15:0] drop_cnt_o;

   tx_pkt_saf_buf #(.DWIDTH(64), .AWIDTH(4), .PCW(8), .DROP_ON_ERR(1)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .in_data_i(in_data_i), .in_empty_i(in_empty_i), .in_sop_i(in_sop_i),
      .in_eop_i(in_eop_i), .in_err_i(in_err_i), .in_val_i(in_val_i),
      .in_ready_o(in_ready_o),
      .out_data_o(out_data_o), .out_empty_o(out_empty_o), .out_sop_o(out_sop_o),
      .out_eop_o(out_eop_o), .out_val_o(out_val_o), .out_ready_i(out_ready_i),
      .flush_i(flush_i), .pkt_cnt_o(pkt_cnt_o), .used_words_o(used_words_o),
      .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic [68:0] obq[$];
   int          obc[$];
   always @(negedge clk_i) begin
      if (rst_n_i && out_val_o && out_ready_i) begin
         obq.push_back({out_data_o, out_empty_o, out_sop_o, out_eop_o});
         obc.push_back(cyc);
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic [2:0] e, input logic s, input logic eo, input logic er);
      in_data_i  = d;
      in_empty_i = e;
      in_sop_i   = s;
      in_eop_i   = eo;
      in_err_i   = er;
      in_val_i   = 1'b1;
      step();
      in_val_i = 1'b0;
      in_sop_i = 1'b0;
      in_eop_i = 1'b0;
      in_err_i = 1'b0;
   endtask

   task automatic clr_q();
      obq.delete();
      obc.delete();
   endtask

   task automatic do_reset();
      #2 rst_n_i = 1'b0;
      #13 rst_n_i = 1'b1;
      step();
      clr_q();
   endtask

   function automatic logic [68:0] obs_at(input int i);
      return (obq.size() > i) ? obq[i] : 69'bx;
   endfunction

   int n, rdy_low;

   initial begin
      rst_n_i = 1'b0; in_data_i = '0; in_empty_i = '0; in_sop_i = 0; in_eop_i = 0;
      in_err_i = 0; in_val_i = 0; out_ready_i = 0; flush_i = 0;

      // reset state
      #12;
      chk("rst_out_val", 69'(out_val_o), 69'd0);
      chk("rst_in_ready", 69'(in_ready_o), 69'd0);
      chk("rst_pkt_cnt", 69'(pkt_cnt_o), 69'd0);
      chk("rst_used", 69'(used_words_o), 69'd0);
      chk("rst_drop", 69'(drop_cnt_o), 69'd0);
      #1 rst_n_i = 1'b1;
      step();
      chk("post_rst_ready", 69'(in_ready_o), 69'd1);

      // 3-beat packet, latency and streaming
      out_ready_i = 1'b1;
      clr_q();
      beat(64'h1000, 3'd0, 1, 0, 0);
      beat(64'h1001, 3'd0, 0, 0, 0);
      n = cyc;
      beat(64'h1002, 3'd5, 0, 1, 0);
      chk("p3_pkt_cnt1", 69'(pkt_cnt_o), 69'd1);
      repeat (5) step();
      chk("p3_count", 69'(obq.size()), 69'd3);
      chk("p3_b0", obs_at(0), {64'h1000, 3'd0, 1'b1, 1'b0});
      chk("p3_b1", obs_at(1), {64'h1001, 3'd0, 1'b0, 1'b0});
      chk("p3_b2", obs_at(2), {64'h1002, 3'd5, 1'b0, 1'b1});
      for (int i = 0; i < 3; i++)
         chk("p3_cycle", 69'((obc.size() > i) ? obc[i] - n : -1), 69'(2 + i));
      chk("p3_pkt_cnt0", 69'(pkt_cnt_o), 69'd0);

      // errored packet dropped, next packet passes
      clr_q();
      beat(64'h2000, 3'd0, 1, 0, 0);
      beat(64'h2001, 3'd2, 0, 1, 1);
      repeat (4) step();
      chk("err_no_out", 69'(obq.size()), 69'd0);
      chk("err_drop", 69'(drop_cnt_o), 69'd1);
      chk("err_used", 69'(used_words_o), 69'd0);
      beat(64'h2100, 3'd0, 1, 0, 0);
      beat(64'h2101, 3'd7, 0, 1, 0);
      repeat (6) step();
      chk("err_next_cnt", 69'(obq.size()), 69'd2);
      chk("err_next_b0", obs_at(0), {64'h2100, 3'd0, 1'b1, 1'b0});
      chk("err_next_b1", obs_at(1), {64'h2101, 3'd7, 1'b0, 1'b1});

      // oversize packet
      do_reset();
      rdy_low = 0;
      for (int i = 0; i < 20; i++) begin
         if (!in_ready_o) rdy_low++;
         beat(64'h3000 + 64'(i), 3'd0, i == 0, i == 19, 0);
      end
      repeat (2) step();
      chk("ovf_ready_low", 69'(rdy_low), 69'd0);
      chk("ovf_drop", 69'(drop_cnt_o), 69'd1);
      chk("ovf_used", 69'(used_words_o), 69'd0);
      chk("ovf_no_out", 69'(obq.size()), 69'd0);
      beat(64'h3100, 3'd0, 1, 0, 0);
      beat(64'h3101, 3'd1, 0, 1, 0);
      repeat (6) step();
      chk("ovf_next_cnt", 69'(obq.size()), 69'd2);
      chk("ovf_next_b0", obs_at(0), {64'h3100, 3'd0, 1'b1, 1'b0});
      chk("ovf_next_b1", obs_at(1), {64'h3101, 3'd1, 1'b0, 1'b1});

      // fill with output stalled
      do_reset();
      out_ready_i = 1'b0;
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 4; b++)
            beat(64'h4000 + 64'(p * 16 + b), 3'd0, b == 0, b == 3, 0);
      repeat (2) step();
      chk("full_pkt_cnt", 69'(pkt_cnt_o), 69'd4);
      chk("full_used", 69'(used_words_o), 69'd16);
      for (int b = 0; b < 4; b++)
         beat(64'h4400 + 64'(b), 3'd0, b == 0, b == 3, 0);
      repeat (2) step();
      chk("full_drop", 69'(drop_cnt_o), 69'd1);
      chk("full_pkt_cnt2", 69'(pkt_cnt_o), 69'd4);
      chk("full_used2", 69'(used_words_o), 69'd16);
      out_ready_i = 1'b1;
      repeat (22) step();
      chk("full_out_cnt", 69'(obq.size()), 69'd16);
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 4; b++)
            chk("full_beat", obs_at(p * 4 + b),
                {64'h4000 + 64'(p * 16 + b), 3'd0, b == 0, b == 3});
      chk("full_pkt_cnt0", 69'(pkt_cnt_o), 69'd0);
      chk("full_used0", 69'(used_words_o), 69'd0);

      // commit and output eop in the same cycle
      do_reset();
      beat(64'h5000, 3'd0, 1, 1, 0);
      chk("same_pkt_a", 69'(pkt_cnt_o), 69'd1);
      beat(64'h5100, 3'd0, 1, 0, 0);
      chk("same_out_eop", 69'({out_val_o, out_eop_o}), 69'b11);
      beat(64'h5101, 3'd4, 0, 1, 0);
      chk("same_pkt_b", 69'(pkt_cnt_o), 69'd1);
      repeat (6) step();
      chk("same_out_cnt", 69'(obq.size()), 69'd3);
      chk("same_pkt_end", 69'(pkt_cnt_o), 69'd0);

      // flush during beat 2 of 4
      clr_q();
      beat(64'h6000, 3'd0, 1, 0, 0);
      chk("fl_used1", 69'(used_words_o), 69'd1);
      flush_i = 1'b1;
      beat(64'h6001, 3'd0, 0, 0, 0);
      flush_i = 1'b0;
      chk("fl_used0", 69'(used_words_o), 69'd0);
      beat(64'h6002, 3'd0, 0, 0, 0);
      beat(64'h6003, 3'd0, 0, 1, 0);
      repeat (4) step();
      chk("fl_no_out", 69'(obq.size()), 69'd0);
      chk("fl_pkt", 69'(pkt_cnt_o), 69'd0);
      chk("fl_used_end", 69'(used_words_o), 69'd0);
      chk("fl_drop", 69'(drop_cnt_o), 69'd0);
      beat(64'h6100, 3'd1, 1, 1, 0);
      repeat (4) step();
      chk("fl_next_cnt", 69'(obq.size()), 69'd1);
      chk("fl_next_b0", obs_at(0), {64'h6100, 3'd1, 1'b1, 1'b1});

      // async reset mid-output
      clr_q();
      for (int b = 0; b < 4; b++)
         beat(64'h7000 + 64'(b), 3'd0, b == 0, b == 3, 0);
      repeat (2) step();
      chk("ar_streaming", 69'(out_val_o), 69'd1);
      #3 rst_n_i = 1'b0;
      #1;
      chk("ar_val_now", 69'(out_val_o), 69'd0);
      chk("ar_pkt_now", 69'(pkt_cnt_o), 69'd0);
      chk("ar_ready_now", 69'(in_ready_o), 69'd0);
      #8 rst_n_i = 1'b1;
      clr_q();
      repeat (6) step();
      chk("ar_no_stale", 69'(obq.size()), 69'd0);
      chk("ar_pkt", 69'(pkt_cnt_o), 69'd0);
      chk("ar_used", 69'(used_words_o), 69'd0);
      chk("ar_drop", 69'(drop_cnt_o), 69'd0);
      chk("ar_ready", 69'(in_ready_o), 69'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
